// File: rtl/fir_mac_sequencer_if.sv
// Handshake and memory/MAC control bundle between the FIR sequencer and its surroundings.
// The master side is the sequencer; the slave side is the sample source, RAM/ROM and MAC.
interface fir_mac_sequencer_if #(
   parameter int unsigned TAPS = 8,
   parameter int unsigned DW   = 8
);
   localparam int unsigned AW = (TAPS > 1) ? $clog2(TAPS) : 1;

   logic          in_valid;
   logic          in_ready;
   logic [DW-1:0] in_data;
   logic          samp_we;
   logic [AW-1:0] samp_waddr;
   logic [DW-1:0] samp_wdata;
   logic [AW-1:0] samp_raddr;
   logic [AW-1:0] coef_addr;
   logic          mac_clr;
   logic          mac_en;
   logic          tap_valid;
   logic          out_valid;
   logic          out_ready;

   modport master (
      input  in_valid, in_data, out_ready,
      output in_ready, samp_we, samp_waddr, samp_wdata, samp_raddr, coef_addr,
             mac_clr, mac_en, tap_valid, out_valid
   );

   modport slave (
      output in_valid, in_data, out_ready,
      input  in_ready, samp_we, samp_waddr, samp_wdata, samp_raddr, coef_addr,
             mac_clr, mac_en, tap_valid, out_valid
   );
endinterface

// File: rtl/fir_mac_sequencer.sv
// Control sequencer for a time-multiplexed FIR: accepts a sample, writes it to the circular
// sample RAM, steps the shared MAC through all taps, then holds the result until taken.
module fir_mac_sequencer #(
   parameter int unsigned TAPS = 8,
   parameter int unsigned DW   = 8
) (
   input  logic clk,
   input  logic rst_n,
   input  logic en,
   input  logic flush,
   output logic busy,
   fir_mac_sequencer_if.master bus
);
   localparam int unsigned AW = (TAPS > 1) ? $clog2(TAPS) : 1;
   localparam int unsigned FW = $clog2(TAPS + 1);
   localparam logic [AW-1:0] LastIdx = AW'(TAPS - 1);
   localparam logic [FW-1:0] FillMax = FW'(TAPS);

   typedef enum logic [1:0] {StIdle, StLoad, StMac, StDone} state_e;

   state_e        state_q, state_d;
   logic [AW-1:0] wr_ptr_q, wr_ptr_d;
   logic [AW-1:0] k_q, k_d;
   logic [FW-1:0] fill_q, fill_d;
   logic [DW-1:0] wdata_q, wdata_d;
   logic [AW-1:0] raddr;
   logic          accept;

   assign bus.in_ready   = (state_q == StIdle) & en & ~flush;
   assign accept         = bus.in_valid & bus.in_ready;
   assign busy           = (state_q != StIdle);
   assign bus.samp_wdata = wdata_q;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q  <= StIdle;
         wr_ptr_q <= '0;
         k_q      <= '0;
         fill_q   <= '0;
         wdata_q  <= '0;
      end else begin
         state_q  <= state_d;
         wr_ptr_q <= wr_ptr_d;
         k_q      <= k_d;
         fill_q   <= fill_d;
         wdata_q  <= wdata_d;
      end
   end

   always_comb begin
      state_d  = state_q;
      wr_ptr_d = wr_ptr_q;
      k_d      = k_q;
      fill_d   = fill_q;
      wdata_d  = wdata_q;
      if (flush) begin
         state_d  = StIdle;
         wr_ptr_d = '0;
         k_d      = '0;
         fill_d   = '0;
      end else begin
         unique case (state_q)
            StIdle: begin
               if (accept) begin
                  wdata_d = bus.in_data;
                  state_d = StLoad;
               end
            end
            StLoad: begin
               fill_d  = (fill_q == FillMax) ? fill_q : fill_q + 1'b1;
               k_d     = '0;
               state_d = StMac;
            end
            StMac: begin
               if (k_q == LastIdx) begin
                  k_d     = '0;
                  state_d = StDone;
               end else begin
                  k_d = k_q + 1'b1;
               end
            end
            StDone: begin
               if (bus.out_ready) begin
                  wr_ptr_d = (wr_ptr_q == LastIdx) ? '0 : wr_ptr_q + 1'b1;
                  state_d  = StIdle;
               end
            end
            default: state_d = StIdle;
         endcase
      end
   end

   // Newest sample sits at wr_ptr; tap k reads k samples back, wrapping at TAPS explicitly.
   always_comb begin
      if (wr_ptr_q >= k_q) begin
         raddr = wr_ptr_q - k_q;
      end else begin
         raddr = AW'(TAPS - 32'(k_q) + 32'(wr_ptr_q));
      end
   end

   always_comb begin
      bus.samp_we    = 1'b0;
      bus.samp_waddr = '0;
      bus.samp_raddr = '0;
      bus.coef_addr  = '0;
      bus.mac_clr    = 1'b0;
      bus.mac_en     = 1'b0;
      bus.tap_valid  = 1'b0;
      bus.out_valid  = 1'b0;
      unique case (state_q)
         StLoad: begin
            bus.samp_we    = 1'b1;
            bus.samp_waddr = wr_ptr_q;
            bus.mac_clr    = 1'b1;
         end
         StMac: begin
            bus.mac_en     = 1'b1;
            bus.coef_addr  = k_q;
            bus.samp_raddr = raddr;
            bus.tap_valid  = (32'(k_q) < 32'(fill_q));
         end
         StDone: bus.out_valid = 1'b1;
         default: ;
      endcase
   end
endmodule
